// File: rtl/ifu_fetch.sv
// Purpose : IFU fetch sequencer; one-word buffer plus 16-bit partial register
//           present aligned, compressed and word-spanning RV32C instructions.
// Latency : buffer/span hit is combinational; miss costs 2+ cycles;
//           a spanning instruction costs 2 cycles on a hit and 4 on a miss.
// Backpr. : decoder backpressure via dec_ready (stall = ~(instr_valid & dec_ready));
//           memory side is req/ack, req held until ack, one transaction in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   curr_pc             address of the instruction to deliver (bit 0 ignored)
//   dec_ready           decoder accepts instr this cycle
//   invalidate          drop buffer and partial register (fence.i)
//   stall, compressed   back to the PC
//   instr, instr_valid  to the decoder
//   imem_req/addr/ack/rdata  instruction-memory port (word addresses)
module ifu_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] curr_pc,
  input  logic            dec_ready,
  input  logic            invalidate,
  output logic            stall,
  output logic            compressed,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FETCH    = 2'd1,
    FETCH_HI = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [XLEN-1:0]   buf_addr_q, buf_addr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [15:0]       part_q, part_d;
  logic [XLEN-1:0]   part_addr_q, part_addr_d;
  logic              part_valid_q, part_valid_d;
  logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
  // Set when invalidate hits an outstanding request: its data must not fill the buffer.
  logic              drop_q, drop_d;

  logic [XLEN-1:0]   w_addr;
  logic [XLEN-1:0]   w_next;
  logic              h_sel;
  logic [15:0]       half;
  logic              is_c;
  logic              buf_hit;
  logic              span_hit;
  logic              unused_pc0;

  assign unused_pc0 = curr_pc[0];

  assign w_addr   = {curr_pc[XLEN-1:2], 2'b00};
  assign w_next   = w_addr + XLEN'(4);   // wraps modulo 2^XLEN
  assign h_sel    = curr_pc[1];
  assign half     = h_sel ? buf_data_q[31:16] : buf_data_q[15:0];
  assign is_c     = (half[1:0] != 2'b11);
  assign buf_hit  = buf_valid_q && (buf_addr_q == w_addr);
  // Lower half of a 32-bit instruction sits in part, upper half in the buffered next word.
  assign span_hit = part_valid_q && (part_addr_q == w_addr) &&
                    buf_valid_q && (buf_addr_q == w_next) && h_sel;

  assign imem_addr = imem_addr_q;

  always_comb begin
    state_d      = state_q;
    buf_data_d   = buf_data_q;
    buf_addr_d   = buf_addr_q;
    buf_valid_d  = buf_valid_q;
    part_d       = part_q;
    part_addr_d  = part_addr_q;
    part_valid_d = part_valid_q;
    imem_addr_d  = imem_addr_q;
    drop_d       = drop_q;
    instr_valid  = 1'b0;
    instr        = 32'd0;
    compressed   = 1'b0;
    imem_req     = 1'b0;

    case (state_q)
      RUN: begin
        if (invalidate) begin
          buf_valid_d  = 1'b0;
          part_valid_d = 1'b0;
        end else if (buf_hit && !h_sel) begin
          instr_valid = 1'b1;
          compressed  = is_c;
          instr       = is_c ? {16'd0, half} : buf_data_q;
        end else if (buf_hit && is_c) begin
          instr_valid = 1'b1;
          compressed  = 1'b1;
          instr       = {16'd0, half};
        end else if (span_hit) begin
          instr_valid = 1'b1;
          compressed  = 1'b0;
          instr       = {buf_data_q[15:0], part_q};
        end else if (buf_hit) begin
          // 32-bit instruction starting in the upper half: keep that half and
          // fetch the following word; the span hit then serves it.
          part_d       = half;
          part_addr_d  = w_addr;
          part_valid_d = 1'b1;
          imem_addr_d  = w_next;
          state_d      = FETCH_HI;
        end else begin
          imem_addr_d = w_addr;
          state_d     = FETCH;
        end
      end

      FETCH, FETCH_HI: begin
        imem_req = 1'b1;
        if (invalidate) begin
          buf_valid_d  = 1'b0;
          part_valid_d = 1'b0;
          drop_d       = 1'b1;
        end
        if (imem_ack) begin
          if (!drop_q && !invalidate) begin
            buf_data_d  = imem_rdata;
            buf_addr_d  = imem_addr_q;
            buf_valid_d = 1'b1;
          end
          drop_d  = 1'b0;
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Decoder-facing outputs read as idle while reset is held.
    if (rst) begin
      instr_valid = 1'b0;
      instr       = 32'd0;
      compressed  = 1'b0;
    end

    stall = ~(instr_valid & dec_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      buf_data_q   <= 32'd0;
      buf_addr_q   <= '0;
      buf_valid_q  <= 1'b0;
      part_q       <= 16'd0;
      part_addr_q  <= '0;
      part_valid_q <= 1'b0;
      imem_addr_q  <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_data_q   <= buf_data_d;
      buf_addr_q   <= buf_addr_d;
      buf_valid_q  <= buf_valid_d;
      part_q       <= part_d;
      part_addr_q  <= part_addr_d;
      part_valid_q <= part_valid_d;
      imem_addr_q  <= imem_addr_d;
      drop_q       <= drop_d;
    end
  end

endmodule
